// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receive deserializer with parity/framing/break status
//
// Ports:
//   clk_i, rst_n_i      system clock, asynchronous active-low reset
//   rxclk_i             one-cycle enable at 16x the baud rate
//   rxclear_i           synchronous abort back to idle (outputs hold)
//   wls_i               word length select: 00=5 .. 11=8 data bits
//   stb_i               stop-bit setting; only the first stop bit is checked
//   pen_i, eps_i, sp_i  parity enable, even-parity select, stick parity
//   sin_i               asynchronous serial input, idles high
//   dout_o              last received word, unused upper bits zero
//   pe_o, fe_o, bi_o    parity error, framing error, break for the last frame
//   rxfinished_o        one-cycle pulse when dout_o and the status bits update

module uart_receiver (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rxclk_i,
    input  logic       rxclear_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sp_i,
    input  logic       sin_i,
    output logic [7:0] dout_o,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       rxfinished_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        MWAIT = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic       sin_meta_q, sin_sync_q;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic       par_acc_q, par_acc_d;
    logic       any_one_q, any_one_d;
    logic       perr_q, perr_d;
    logic [7:0] dout_q, dout_d;
    logic       pe_q, pe_d;
    logic       fe_q, fe_d;
    logic       bi_q, bi_d;
    logic       rxfin_q, rxfin_d;

    logic       tick_last;
    logic       last_bit;
    logic       stb_unused;

    // Only the first stop bit is ever sampled, so the stop-bit length is not needed.
    assign stb_unused = stb_i;

    assign tick_last = (tick_q == 4'd15);
    assign last_bit  = (bit_cnt_q == ({1'b0, wls_i} + 3'd4));

    // Two-flop synchronizer, reset to the idle line level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sin_meta_q <= 1'b1;
            sin_sync_q <= 1'b1;
        end else begin
            sin_meta_q <= sin_i;
            sin_sync_q <= sin_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; everything advances only on rxclk_i, abort wins.
    always_comb begin
        state_d = state_q;
        if (rxclear_i) begin
            state_d = IDLE;
        end else if (rxclk_i) begin
            case (state_q)
                IDLE:  if (!sin_sync_q) state_d = START;
                START: if (tick_q == 4'd7) state_d = sin_sync_q ? IDLE : DATA;
                DATA:  if (tick_last && last_bit) state_d = pen_i ? PAR : STOP;
                PAR:   if (tick_last) state_d = STOP;
                STOP:  if (tick_last) state_d = sin_sync_q ? IDLE : MWAIT;
                MWAIT: if (sin_sync_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM output / datapath logic
    always_comb begin
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_acc_d = par_acc_q;
        any_one_d = any_one_q;
        perr_d    = perr_q;
        dout_d    = dout_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        bi_d      = bi_q;
        rxfin_d   = 1'b0;
        if (rxclear_i) begin
            tick_d    = 4'd0;
            bit_cnt_d = 3'd0;
        end else if (rxclk_i) begin
            case (state_q)
                IDLE: begin
                    tick_d    = 4'd0;
                    bit_cnt_d = 3'd0;
                    if (!sin_sync_q) begin
                        data_d    = 8'h00;
                        par_acc_d = 1'b0;
                        any_one_d = 1'b0;
                        perr_d    = 1'b0;
                    end
                end
                START: begin
                    // Start bit confirmed mid-bit; from here every 16th tick is a bit centre.
                    tick_d = (tick_q == 4'd7) ? 4'd0 : tick_q + 4'd1;
                end
                DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_last) begin
                        data_d[bit_cnt_q] = sin_sync_q;
                        par_acc_d         = par_acc_q ^ sin_sync_q;
                        any_one_d         = any_one_q | sin_sync_q;
                        bit_cnt_d         = last_bit ? 3'd0 : bit_cnt_q + 3'd1;
                    end
                end
                PAR: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_last) begin
                        // Stick parity compares the bit alone against ~eps; otherwise the
                        // data+parity XOR must equal ~eps (0 for even, 1 for odd).
                        perr_d    = (sp_i ? sin_sync_q : (par_acc_q ^ sin_sync_q)) ^ ~eps_i;
                        any_one_d = any_one_q | sin_sync_q;
                    end
                end
                STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_last) begin
                        dout_d  = data_q;
                        pe_d    = perr_q;
                        fe_d    = ~sin_sync_q;
                        bi_d    = ~(any_one_q | sin_sync_q);
                        rxfin_d = 1'b1;
                    end
                end
                MWAIT: begin
                    tick_d = 4'd0;
                end
                default: begin
                    tick_d    = 4'd0;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tick_q    <= 4'd0;
            bit_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            par_acc_q <= 1'b0;
            any_one_q <= 1'b0;
            perr_q    <= 1'b0;
            dout_q    <= 8'h00;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            bi_q      <= 1'b0;
            rxfin_q   <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_acc_q <= par_acc_d;
            any_one_q <= any_one_d;
            perr_q    <= perr_d;
            dout_q    <= dout_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            bi_q      <= bi_d;
            rxfin_q   <= rxfin_d;
        end
    end

    assign dout_o       = dout_q;
    assign pe_o         = pe_q;
    assign fe_o         = fe_q;
    assign bi_o         = bi_q;
    assign rxfinished_o = rxfin_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized self-checking bench for uart_receiver
//
// Drives serial frames at 16 rxclk per bit (rxclk every 4 clk) and compares each
// received word/status against a frame-level model; logs every rxfinished pulse.

module tb_uart_receiver;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxclk = 1'b0;
    logic       rxclear = 1'b0;
    logic [1:0] wls = 2'b11;
    logic       stb = 1'b0;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sp = 1'b0;
    logic       sin = 1'b1;
    logic [7:0] dout;
    logic       pe, fe, bi, rxfinished;

    int          n_checks = 0;
    int          n_pass = 0;
    int          div_cnt = 0;
    logic [10:0] log_q[$];
    logic [10:0] last_exp = 11'h000;

    uart_receiver dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rxclk_i      (rxclk),
        .rxclear_i    (rxclear),
        .wls_i        (wls),
        .stb_i        (stb),
        .pen_i        (pen),
        .eps_i        (eps),
        .sp_i         (sp),
        .sin_i        (sin),
        .dout_o       (dout),
        .pe_o         (pe),
        .fe_o         (fe),
        .bi_o         (bi),
        .rxfinished_o (rxfinished)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        div_cnt = (div_cnt + 1) % 4;
        rxclk = (div_cnt == 0);
    end

    // Every cycle rxfinished is high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (rxfinished) log_q.push_back({bi, fe, pe, dout});
    end

    // Expected {bi, fe, pe, dout} for one frame, from the line-level frame rules.
    function automatic logic [10:0] model(input logic [7:0] data, input logic [1:0] w,
                                          input logic p_en, input logic e, input logic s,
                                          input logic pbit, input logic stopb);
        int         n;
        logic [7:0] d;
        logic       good, pe_e, bi_e;
        n    = int'(w) + 5;
        d    = data & 8'((1 << n) - 1);
        good = s ? ~e : (e ? ^d : ~^d);
        pe_e = p_en && (pbit !== good);
        bi_e = (d == 8'h00) && (!p_en || !pbit) && !stopb;
        return {bi_e, ~stopb, pe_e, d};
    endfunction

    task automatic drive_bit(input logic b);
        sin = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle(input int bits);
        sin = 1'b1;
        repeat (bits * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
        drive_bit(1'b0);
        for (int i = 0; i < int'(wls) + 5; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bi, fe, pe, dout} !== 11'h000) $display("FAIL reset_outputs: got %h expected %h", {bi, fe, pe, dout}, 11'h000);
        else n_pass++;
        n_checks++;
        if (rxfinished !== 1'b0) $display("FAIL reset_rxfinished: got %b expected 0", rxfinished);
        else n_pass++;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_8n1();
        int          base;
        logic [10:0] exp;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        base = log_q.size();
        exp = model(8'h55, wls, pen, eps, sp, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (log_q.size() !== base + 1) $display("FAIL 8n1_pulses: got %0d expected 1", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if (log_q[$] !== exp) $display("FAIL 8n1_result: got %h expected %h", log_q[$], exp);
        else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_7e1_bad_parity();
        int          base;
        logic [10:0] exp;
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        base = log_q.size();
        exp = model(8'h41, wls, pen, eps, sp, 1'b1, 1'b1);
        send_frame(8'h41, 1'b1, 1'b1);
        idle(1);
        n_checks++;
        if (log_q.size() !== base + 1) $display("FAIL 7e1_pulses: got %0d expected 1", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if (log_q[$] !== exp) $display("FAIL 7e1_result: got %h expected %h", log_q[$], exp);
        else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_glitch();
        int base;
        base = log_q.size();
        sin = 1'b0;
        repeat (16) @(negedge clk);
        idle(2);
        n_checks++;
        if (log_q.size() !== base) $display("FAIL glitch_pulses: got %0d expected 0", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if ({bi, fe, pe, dout} !== last_exp) $display("FAIL glitch_hold: got %h expected %h", {bi, fe, pe, dout}, last_exp);
        else n_pass++;
    endtask

    task automatic test_break();
        int          base;
        logic [10:0] exp;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        base = log_q.size();
        exp = model(8'h00, wls, pen, eps, sp, 1'b0, 1'b0);
        sin = 1'b0;
        repeat (12 * BIT_CLK) @(negedge clk);
        n_checks++;
        if (log_q.size() !== base + 1) $display("FAIL break_pulses: got %0d expected 1", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if (log_q[$] !== exp) $display("FAIL break_result: got %h expected %h", log_q[$], exp);
        else n_pass++;
        idle(11);
        n_checks++;
        if (log_q.size() !== base + 1) $display("FAIL break_mwait: got %0d expected 1", log_q.size() - base);
        else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_stick_parity();
        int          base;
        logic [10:0] exp;
        wls = 2'b00; pen = 1'b1; eps = 1'b0; sp = 1'b1;
        for (int k = 0; k < 2; k++) begin
            base = log_q.size();
            exp = model(8'h1F, wls, pen, eps, sp, (k == 0), 1'b1);
            send_frame(8'h1F, (k == 0), 1'b1);
            idle(1);
            n_checks++;
            if (log_q.size() !== base + 1) $display("FAIL stick%0d_pulses: got %0d expected 1", k, log_q.size() - base);
            else n_pass++;
            n_checks++;
            if (log_q[$] !== exp) $display("FAIL stick%0d_result: got %h expected %h", k, log_q[$], exp);
            else n_pass++;
            last_exp = exp;
        end
    endtask

    task automatic test_rxclear();
        int          base;
        logic [10:0] exp;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        base = log_q.size();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        sin = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        rxclear = 1'b1;
        @(negedge clk);
        rxclear = 1'b0;
        idle(12);
        n_checks++;
        if (log_q.size() !== base) $display("FAIL rxclear_pulses: got %0d expected 0", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if ({bi, fe, pe, dout} !== last_exp) $display("FAIL rxclear_hold: got %h expected %h", {bi, fe, pe, dout}, last_exp);
        else n_pass++;
        exp = model(8'hA3, wls, pen, eps, sp, 1'b0, 1'b1);
        send_frame(8'hA3, 1'b0, 1'b1);
        idle(1);
        n_checks++;
        if (log_q.size() !== base + 1) $display("FAIL rxclear_next_pulses: got %0d expected 1", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if (log_q[$] !== exp) $display("FAIL rxclear_next_result: got %h expected %h", log_q[$], exp);
        else n_pass++;
        last_exp = exp;
    endtask

    task automatic test_reset_midframe();
        int base;
        base = log_q.size();
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        sin = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rxfinished, bi, fe, pe, dout} !== 12'h000)
            $display("FAIL midreset_async: got %h expected %h", {rxfinished, bi, fe, pe, dout}, 12'h000);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        n_checks++;
        if (log_q.size() !== base) $display("FAIL midreset_pulses: got %0d expected 0", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if ({bi, fe, pe, dout} !== 11'h000) $display("FAIL midreset_hold: got %h expected %h", {bi, fe, pe, dout}, 11'h000);
        else n_pass++;
        last_exp = 11'h000;
    endtask

    task automatic test_random();
        int          base;
        logic [10:0] exp;
        logic [7:0]  d;
        logic        pbit, stopb;
        for (int k = 0; k < 12; k++) begin
            wls   = 2'($urandom_range(0, 3));
            pen   = 1'($urandom_range(0, 1));
            eps   = 1'($urandom_range(0, 1));
            sp    = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            if (k == 3) d = 8'h00;
            pbit  = 1'($urandom_range(0, 1));
            stopb = ($urandom_range(0, 3) != 0);
            base  = log_q.size();
            exp   = model(d, wls, pen, eps, sp, pbit, stopb);
            send_frame(d, pbit, stopb);
            idle(1);
            n_checks++;
            if (log_q.size() !== base + 1) $display("FAIL rand%0d_pulses: got %0d expected 1", k, log_q.size() - base);
            else n_pass++;
            n_checks++;
            if (log_q[$] !== exp) $display("FAIL rand%0d_result: got %h expected %h", k, log_q[$], exp);
            else n_pass++;
            last_exp = exp;
        end
    endtask

    task automatic test_back_to_back();
        int          base;
        logic [10:0] exp1, exp2;
        wls = 2'b11; pen = 1'b1; eps = 1'b0; sp = 1'b0;
        base = log_q.size();
        exp1 = model(8'h3C, wls, pen, eps, sp, 1'b1, 1'b1);
        exp2 = model(8'hC5, wls, pen, eps, sp, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        send_frame(8'hC5, 1'b1, 1'b1);
        idle(1);
        n_checks++;
        if (log_q.size() !== base + 2) $display("FAIL b2b_pulses: got %0d expected 2", log_q.size() - base);
        else n_pass++;
        n_checks++;
        if (log_q[base] !== exp1) $display("FAIL b2b_first: got %h expected %h", log_q[base], exp1);
        else n_pass++;
        n_checks++;
        if (log_q[base + 1] !== exp2) $display("FAIL b2b_second: got %h expected %h", log_q[base + 1], exp2);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1_bad_parity();
        test_glitch();
        test_break();
        test_stick_parity();
        test_rxclear();
        test_reset_midframe();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 CLK  in  1  system clock; all state changes on its rising edge.
REQ-003 RST_N  in  1  asynchronous active-low reset.
REQ-004 RXCLK  in  1  one-CLK-wide enable pulse at 16x the baud rate, from the baud counter.
REQ-005 RXCLEAR  in  1  synchronous abort; returns the receiver to idle.
REQ-006 WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-007 STB  in  1  stop-bit setting; accepted but only the first stop bit is checked.
REQ-008 PEN  in  1  parity enable.
REQ-009 EPS  in  1  even parity select: 1=even, 0=odd.
REQ-010 SP  in  1  stick parity.
REQ-011 SIN  in  1  asynchronous serial input; idles high.
REQ-012 DOUT  out  8  received word, LSB first on the wire, bit i stored at DOUT[i], unused upper bits 0.
REQ-013 PE / FE / BI  out  1 each  parity error / framing error / break indication for the last frame.
REQ-014 RXFINISHED  out  1  one-CLK pulse when DOUT, PE, FE and BI become valid.

Function
REQ-015 Input sync: SIN SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (2 CLK latency).
REQ-016 Oversampling counter: 4-bit tick counter, advanced only on RXCLK; it wraps 15->0.
REQ-017 FSM states SHALL be IDLE, START, DATA, PAR, STOP and MWAIT.
REQ-018 IDLE: when synced SIN=0 at an RXCLK, go to START with the tick counter cleared.
REQ-019 START: at the 8th RXCLK (counter=7), sample SIN.
- 0: clear the counter and go to DATA.
- 1: glitch; return to IDLE with no output change.
REQ-020 DATA: sample one bit every 16 RXCLK (counter=15); after WLS+5 bits go to PAR if PEN=1, else to STOP.
REQ-021 PAR: sample the parity bit 16 RXCLK after the last data bit.
- SP=1: expected parity bit = ~EPS.
- SP=0, EPS=1: XOR(data, parity) SHALL be 0.
- SP=0, EPS=0: XOR(data, parity) SHALL be 1.
- Mismatch sets PE at frame end.
REQ-022 STOP: sample 16 RXCLK later.
- FE = ~SIN.
- BI = 1 iff all data bits, the parity bit (if enabled) and the stop bit are 0.
REQ-023 Frame end: on the CLK after the stop-sample RXCLK, DOUT, PE, FE and BI update together and RXFINISHED pulses for exactly 1 CLK.
REQ-024 Frame-end transition: go to MWAIT if synced SIN=0, else to IDLE.
REQ-025 MWAIT: stay until synced SIN=1, then go to IDLE; no new start is detected while in MWAIT.
REQ-026 Outputs hold between frames; PE, FE and BI describe only the latest frame and are not sticky.
REQ-027 RXCLEAR=1: next state IDLE, counters zero, no RXFINISHED; DOUT/PE/FE/BI hold. RXCLEAR has priority over RXCLK in the same cycle.
REQ-028 WLS, PEN, EPS and SP SHALL be stable during a frame; behaviour on a mid-frame change is undefined.
REQ-029 Without an RXCLK pulse the FSM and counters SHALL hold.

Reset
REQ-030 RST_N=0 SHALL immediately force all of the following, regardless of CLK, including mid-frame:
- state IDLE, counters 0, synchronizer flops 1;
- DOUT=0x00, PE=FE=BI=0, RXFINISHED=0.

Verification
REQ-031 8N1 (WLS=11, PEN=0), SIN sends 0x55 with a 1 stop bit -> one RXFINISHED pulse, DOUT=0x55, PE=FE=BI=0.
REQ-032 7E1 (WLS=10, PEN=1, EPS=1, SP=0), data 0x41 with parity bit 1 (wrong) -> DOUT=0x41, PE=1, FE=0.
REQ-033 Start glitch: SIN low for 4 RXCLK then high -> no RXFINISHED, outputs unchanged, FSM back in IDLE.
REQ-034 Break, 8N1: SIN held low for 12 bit times then released.
- -> exactly one RXFINISHED pulse with DOUT=0x00, FE=1, BI=1.
- -> no further frame until SIN returns high (MWAIT exit).
REQ-035 5-bit stick parity (WLS=00, PEN=1, SP=1, EPS=0), data 0x1F with parity bit 1 -> DOUT=0x1F, PE=0.
- Repeat with parity bit 0 -> PE=1.
REQ-036 Abort mid-frame, in both cases no RXFINISHED and prior DOUT kept:
- RXCLEAR pulse during bit 3 -> IDLE; the next clean frame 0xA3 is received correctly.
- RST_N low during bit 3 -> all outputs zero, IDLE.
